desc_word_streamer: RTL

//  Transmit side of the NCC descriptor-load interface. Accepts a 16x16 descriptor as 256 8-bit pixels,

---
 rtl/ncc_pkg.sv | 20 ++
 rtl/desc_word_streamer_if.sv | 28 ++
 rtl/desc_word_fifo.sv | 56 +++++
 rtl/desc_word_streamer.sv | 118 +++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
// Shared NCC types: pixel/word widths, descriptor streamer states and the
// packed-word record that travels through the descriptor FIFO.
package ncc_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH
  } stream_state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } desc_word_t;

endpackage

// File: rtl/desc_word_streamer_if.sv
// Pixel-in / packed-word-out bundle of the descriptor streamer.
// slave is the streamer's view, master is the source/NCC side.
interface desc_word_streamer_if;
  import ncc_pkg::*;

  logic [PIX_W-1:0]  pix_in;
  logic              pix_valid;
  logic              pix_sof;
  logic              pix_ready;
  logic [WORD_W-1:0] desc_data_out;
  logic              desc_data_ready;
  logic              desc_ack;
  logic              desc_last;
  logic              desc_done;
  logic              busy;
  logic              sync_err;

  modport slave (
    input  pix_in, pix_valid, pix_sof, desc_ack,
    output pix_ready, desc_data_out, desc_data_ready, desc_last, desc_done, busy, sync_err
  );

  modport master (
    output pix_in, pix_valid, pix_sof, desc_ack,
    input  pix_ready, desc_data_out, desc_data_ready, desc_last, desc_done, busy, sync_err
  );

endinterface

// File: rtl/desc_word_fifo.sv
// Small synchronous FIFO of packed descriptor words; head is read straight
// from the storage registers and forced to zero while empty.
module desc_word_fifo
  import ncc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  desc_word_t push_word,
  input  logic       pop,
  output desc_word_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  desc_word_t      mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define validity and head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

endmodule

// File: rtl/desc_word_streamer.sv
// Packs descriptor pixels four per word (first pixel in the MSB byte), queues
// the words and hands them to the NCC core over a ready/ack handshake.
module desc_word_streamer
  import ncc_pkg::*;
#(
  parameter int PIX_PER_DESC = 256,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  desc_word_streamer_if.slave  io
);

  localparam int              WPD       = PIX_PER_DESC / PIX_PER_WORD;
  localparam int              WC_W      = (WPD > 1) ? $clog2(WPD) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPD - 1);

  stream_state_t   state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [23:0]     part_q, part_d;
  logic            sync_err_q, sync_err_d;

  logic            pix_ready, accept, push, pop;
  logic            fifo_full, fifo_empty;
  desc_word_t      push_word, head;

  // Ready depends only on state and start-of-cycle fullness, never on this cycle's pop.
  assign pix_ready = !rst && ((state_q == IDLE) || (state_q == PACK && !fifo_full));
  assign accept    = io.pix_valid && pix_ready;
  assign pop       = io.desc_ack && !fifo_empty;
  assign push_word = '{last: (word_cnt_q == LAST_WORD), data: {part_q, io.pix_in}};

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    word_cnt_d = word_cnt_q;
    part_d     = part_q;
    sync_err_d = sync_err_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && io.pix_sof) begin
          part_d     = {io.pix_in, 16'h0000};
          lane_d     = 2'd1;
          word_cnt_d = '0;
          state_d    = PACK;
        end
      end
      PACK: begin
        if (accept) begin
          if (io.pix_sof && (lane_q != '0 || word_cnt_q != '0)) begin
            // Resynchronise: drop the partial word, keep queued words untouched.
            sync_err_d = 1'b1;
            part_d     = {io.pix_in, 16'h0000};
            lane_d     = 2'd1;
            word_cnt_d = '0;
          end else if (lane_q == 2'd3) begin
            push   = 1'b1;
            lane_d = 2'd0;
            if (word_cnt_q == LAST_WORD) state_d = FLUSH;
            else word_cnt_d = word_cnt_q + WC_W'(1);
          end else begin
            unique case (lane_q)
              2'd0:    part_d[23:16] = io.pix_in;
              2'd1:    part_d[15:8]  = io.pix_in;
              default: part_d[7:0]   = io.pix_in;
            endcase
            lane_d = lane_q + 2'd1;
          end
        end
      end
      FLUSH: begin
        if (pop && head.last) begin
          state_d    = IDLE;
          word_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      word_cnt_q <= '0;
      part_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_cnt_q <= word_cnt_d;
      part_q     <= part_d;
      sync_err_q <= sync_err_d;
    end
  end

  desc_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign io.pix_ready       = pix_ready;
  assign io.desc_data_out   = head.data;
  assign io.desc_last       = head.last;
  assign io.desc_data_ready = !fifo_empty;
  assign io.desc_done       = (state_q == FLUSH) && pop && head.last;
  assign io.busy            = (state_q != IDLE);
  assign io.sync_err        = sync_err_q;

endmodule
